// File: rtl/sram_arb_pkg.sv
// Shared types and opcode constants for the SRAM request arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  localparam logic [3:0] OFFER_WRITE = 4'h0;
  localparam logic [3:0] OFFER_READ  = 4'h1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/sram_request_arbiter.sv
// Round-robin arbiter feeding one SRAM state machine; one transaction outstanding,
// read responses routed back to the granted requester with a timeout.
module sram_request_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OFFER_W = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESETN,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*OFFER_W-1:0] req_offer,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       resp_err,
  output logic                       sm_cmd_valid,
  input  logic                       sm_cmd_ready,
  output logic [OFFER_W-1:0]         sm_cmd_offer,
  output logic [DATA_W-1:0]          sm_cmd_data,
  input  logic                       sm_rsp_valid,
  input  logic [DATA_W-1:0]          sm_rsp_data,
  output logic                       sm_rsp_ready,
  output logic                       stray_rsp
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_t         state, state_nx;
  logic               pick_any;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      grant_q, ptr_q;
  logic [OFFER_W-1:0] offer_q, pick_offer;
  logic [DATA_W-1:0]  data_q, pick_data;
  logic [TW-1:0]      timer_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [DATA_W-1:0]  resp_data_q;
  logic               resp_err_q, stray_q;
  logic               capture, start_timer, rsp_ok, rsp_to;
  logic [NUM_REQ-1:0] req_ready_c;

  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req (req_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Select the winner's offer/data slice with constant part-selects.
  always_comb begin
    pick_offer = '0;
    pick_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_offer = req_offer[i*OFFER_W +: OFFER_W];
        pick_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready_c = '0;
    capture     = 1'b0;
    start_timer = 1'b0;
    rsp_ok      = 1'b0;
    rsp_to      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready_c = NUM_REQ'(1) << pick_idx;
          capture     = 1'b1;
          state_nx    = ISSUE;
        end
      end
      ISSUE: begin
        if (sm_cmd_ready) begin
          if (offer_q == OFFER_W'(OFFER_READ)) begin
            start_timer = 1'b1;
            state_nx    = WAIT_RSP;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        // A response landing on the final timer cycle beats the timeout.
        if (sm_rsp_valid) begin
          rsp_ok   = 1'b1;
          state_nx = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_to   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      grant_q      <= '0;
      ptr_q        <= '0;
      offer_q      <= '0;
      data_q       <= '0;
      timer_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (capture) begin
        grant_q <= pick_idx;
        offer_q <= pick_offer;
        data_q  <= pick_data;
        ptr_q   <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
      end
      if (start_timer)             timer_q <= '0;
      else if (state == WAIT_RSP)  timer_q <= timer_q + TW'(1);
      if (rsp_ok) begin
        resp_valid_q <= NUM_REQ'(1) << grant_q;
        resp_data_q  <= sm_rsp_data;
        resp_err_q   <= 1'b0;
      end else if (rsp_to) begin
        resp_valid_q <= NUM_REQ'(1) << grant_q;
        resp_data_q  <= '0;
        resp_err_q   <= 1'b1;
      end
      if (sm_rsp_valid && state != WAIT_RSP) stray_q <= 1'b1;
    end
  end

  assign req_ready    = req_ready_c;
  assign sm_cmd_valid = (state == ISSUE);
  assign sm_cmd_offer = offer_q;
  assign sm_cmd_data  = data_q;
  assign sm_rsp_ready = (state == WAIT_RSP);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign stray_rsp    = stray_q;

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Directed self-checking bench for sram_request_arbiter (TIMEOUT overridden to 8).
module tb_sram_request_arbiter;
  import sram_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        ASYNCRESETN = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_offer = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready, resp_valid;
  logic [15:0] resp_data, sm_cmd_data;
  logic        resp_err, sm_cmd_valid, sm_rsp_ready, stray_rsp;
  logic        sm_cmd_ready = 1'b0;
  logic [3:0]  sm_cmd_offer;
  logic        sm_rsp_valid = 1'b0;
  logic [15:0] sm_rsp_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  sram_request_arbiter #(.NUM_REQ(4), .DATA_W(16), .OFFER_W(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .req_valid(req_valid), .req_offer(req_offer), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .sm_cmd_valid(sm_cmd_valid), .sm_cmd_ready(sm_cmd_ready),
    .sm_cmd_offer(sm_cmd_offer), .sm_cmd_data(sm_cmd_data),
    .sm_rsp_valid(sm_rsp_valid), .sm_rsp_data(sm_rsp_data),
    .sm_rsp_ready(sm_rsp_ready), .stray_rsp(stray_rsp)
  );

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    ASYNCRESETN = 1'b0;
    req_valid = '0; sm_cmd_ready = 1'b0; sm_rsp_valid = 1'b0;
    next_cyc();
    next_cyc();
    ASYNCRESETN = 1'b1;
  endtask

  // Grant requester r with a read, complete the command handshake; returns in WAIT_RSP cycle 1.
  task automatic issue_read(input int r);
    req_valid = 4'(1) << r;
    req_offer = 16'(OFFER_READ) << (4 * r);
    sm_cmd_ready = 1'b1;
    next_cyc();
    req_valid = '0;
    next_cyc();
    sm_cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    @(negedge CLK);
    outs = {req_ready, resp_valid, resp_data, resp_err, sm_cmd_valid, sm_cmd_offer,
            sm_cmd_data, sm_rsp_ready, stray_rsp};
    n_checks++;
    if (outs !== 48'h0) begin
      n_fail++; $display("FAIL reset_initial: outputs=%h expected=0", outs);
    end
    next_cyc();
    ASYNCRESETN = 1'b1;
    issue_read(1);
    @(negedge CLK);
    n_checks++;
    if (sm_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_setup_wait: sm_rsp_ready=%b expected=1", sm_rsp_ready);
    end
    #2 ASYNCRESETN = 1'b0;
    #1;
    outs = {req_ready, resp_valid, resp_data, resp_err, sm_cmd_valid, sm_cmd_offer,
            sm_cmd_data, sm_rsp_ready, stray_rsp};
    n_checks++;
    if (outs !== 48'h0) begin
      n_fail++; $display("FAIL reset_mid_wait: outputs=%h expected=0", outs);
    end
    next_cyc();
    ASYNCRESETN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      n_checks++;
      if (resp_valid !== 4'b0000 || sm_rsp_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_dropped c=%0d: resp_valid=%b sm_rsp_ready=%b expected 0000/0",
                 c, resp_valid, sm_rsp_ready);
      end
      next_cyc();
    end
    req_valid = 4'b1111;
    req_offer = {4{OFFER_WRITE}};
    @(negedge CLK);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ptr_zero: req_ready=%b expected=0001", req_ready);
    end
    next_cyc();
    req_valid = '0; sm_cmd_ready = 1'b1;
    next_cyc();
    sm_cmd_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ready;
    logic [15:0] exp_data;
    int g;
    apply_reset();
    req_valid = 4'b1111;
    req_offer = {4{OFFER_WRITE}};
    req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    sm_cmd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      g = (c / 2) % 4;
      exp_ready = (c % 2 == 0) ? (4'(1) << g) : 4'b0000;
      exp_data = 16'hA000 + 16'(g);
      @(negedge CLK);
      n_checks++;
      if (req_ready !== exp_ready || sm_cmd_valid !== 1'(c % 2)) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d: req_ready=%b cmd_valid=%b expected %b/%0d",
                 c, req_ready, sm_cmd_valid, exp_ready, c % 2);
      end
      if (c % 2 == 1) begin
        n_checks++;
        if (sm_cmd_data !== exp_data || sm_cmd_offer !== OFFER_WRITE) begin
          n_fail++;
          $display("FAIL rr_cmd c=%0d: data=%h offer=%h expected %h/%h",
                   c, sm_cmd_data, sm_cmd_offer, exp_data, OFFER_WRITE);
        end
      end
      next_cyc();
    end
    req_valid = '0;
    next_cyc();
    sm_cmd_ready = 1'b0;
  endtask

  task automatic test_read_response();
    apply_reset();
    req_data = 64'h0000_5A5A_0000_0000;
    issue_read(2);
    for (int c = 1; c <= 7; c++) begin
      sm_rsp_valid = (c == 5);
      sm_rsp_data = (c == 5) ? 16'hBEEF : 16'h0000;
      @(negedge CLK);
      n_checks++;
      if (sm_rsp_ready !== (c <= 5) || resp_valid !== ((c == 6) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL read_rsp c=%0d: rsp_ready=%b resp_valid=%b", c, sm_rsp_ready, resp_valid);
      end
      if (c >= 6) begin
        n_checks++;
        if (resp_data !== 16'hBEEF || resp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL read_data c=%0d: resp_data=%h err=%b expected beef/0", c, resp_data, resp_err);
        end
      end
      next_cyc();
    end
  endtask

  // Runs straight after the read test so resp_data starts nonzero.
  task automatic test_timeout();
    issue_read(3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      n_checks++;
      if (sm_rsp_ready !== (c <= 8) || resp_valid !== ((c == 9) ? 4'b1000 : 4'b0000)) begin
        n_fail++;
        $display("FAIL timeout c=%0d: rsp_ready=%b resp_valid=%b", c, sm_rsp_ready, resp_valid);
      end
      if (c == 9) begin
        n_checks++;
        if (resp_data !== 16'h0000 || resp_err !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_err: resp_data=%h err=%b expected 0000/1", resp_data, resp_err);
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req_valid = 4'b0011;
    req_offer = 16'h0005;
    req_data = 64'h0000_0000_5678_1234;
    @(negedge CLK);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL stall_grant: req_ready=%b expected=0001", req_ready);
    end
    next_cyc();
    req_valid = 4'b0010;
    req_offer = 16'h0000;
    req_data = 64'h0000_0000_5678_FFFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      n_checks++;
      if (sm_cmd_valid !== 1'b1 || sm_cmd_offer !== 4'h5 || sm_cmd_data !== 16'h1234 ||
          req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d: valid=%b offer=%h data=%h req_ready=%b expected 1/5/1234/0000",
                 c, sm_cmd_valid, sm_cmd_offer, sm_cmd_data, req_ready);
      end
      next_cyc();
    end
    sm_cmd_ready = 1'b1;
    next_cyc();
    sm_cmd_ready = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (req_ready !== 4'b0010 || resp_valid !== 4'b0000 || sm_rsp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: req_ready=%b resp_valid=%b rsp_ready=%b expected 0010/0000/0",
               req_ready, resp_valid, sm_rsp_ready);
    end
    next_cyc();
    req_valid = '0; sm_cmd_ready = 1'b1;
    next_cyc();
    sm_cmd_ready = 1'b0;
  endtask

  task automatic test_stray_and_race();
    apply_reset();
    sm_rsp_valid = 1'b1;
    sm_rsp_data = 16'h1111;
    next_cyc();
    sm_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if (stray_rsp !== 1'b1 || resp_valid !== 4'b0000) begin
        n_fail++;
        $display("FAIL stray_sticky c=%0d: stray=%b resp_valid=%b expected 1/0000", c, stray_rsp, resp_valid);
      end
      next_cyc();
    end
    issue_read(0);
    for (int c = 1; c <= 10; c++) begin
      sm_rsp_valid = (c == 8);
      sm_rsp_data = (c == 8) ? 16'hCAFE : 16'h0000;
      @(negedge CLK);
      if (c == 9) begin
        n_checks++;
        if (resp_valid !== 4'b0001 || resp_err !== 1'b0 || resp_data !== 16'hCAFE) begin
          n_fail++;
          $display("FAIL race_rsp_wins: resp_valid=%b err=%b data=%h expected 0001/0/cafe",
                   resp_valid, resp_err, resp_data);
        end
      end
      next_cyc();
    end
    apply_reset();
    @(negedge CLK);
    n_checks++;
    if (stray_rsp !== 1'b0) begin
      n_fail++; $display("FAIL stray_reset: stray=%b expected=0", stray_rsp);
    end
    next_cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_response();
    test_timeout();
    test_stall();
    test_stray_and_race();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
